// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: datapath width, fetch reset defaults and IF stage states.
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// Captures the imem word on the first stalled cycle and selects what decode sees (NOP, held word or live imem data).
module if_hold_buf import cpu_pkg::*; #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic            req_valid,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] inst
);

  if_state_t       state;
  logic [XLEN-1:0] hold_inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      hold_inst_q <= '0;
    end else if (redirect) begin
      state <= RUN;
    end else if (stall) begin
      // imem moves on to pc_q after this edge, so grab the word now.
      if (state == RUN) begin
        hold_inst_q <= rdata;
        state       <= HOLD;
      end
    end else begin
      state <= RUN;
    end
  end

  assign inst = !req_valid       ? NOP_INST :
                (state == HOLD)  ? hold_inst_q : rdata;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, imem request and IF/ID outputs with stall hold and EX redirect.
// Optional IF_PERF_CNT_EN adds saturating fetch/stall/redirect event counters.
module if_fetch_stage import cpu_pkg::*; #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_en_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o,
  output logic [XLEN-1:0] id_inst_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_redirect_o,
`endif
  output logic            id_valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else if (redirect_i) begin
      // Word-align the target and drop the fetch already in flight.
      pc_q        <= redirect_pc_i & ~XLEN'(3);
      req_valid_q <= 1'b0;
    end else if (!stall_i) begin
      req_pc_q    <= pc_q;
      req_valid_q <= 1'b1;
      pc_q        <= pc_q + XLEN'(4);
    end
  end

  if_hold_buf #(
    .XLEN     (XLEN),
    .NOP_INST (NOP_INST)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall_i),
    .redirect  (redirect_i),
    .req_valid (req_valid_q),
    .rdata     (imem_rdata_i),
    .inst      (id_inst_o)
  );

  assign imem_en_o   = ~rst;
  assign imem_addr_o = pc_q;
  assign id_pc_o     = req_pc_q;
  assign id_pc4_o    = req_pc_q + XLEN'(4);
  assign id_valid_o  = req_valid_q;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_o    <= '0;
      perf_stall_o    <= '0;
      perf_redirect_o <= '0;
    end else begin
      if (redirect_i && perf_redirect_o != '1)
        perf_redirect_o <= perf_redirect_o + 32'd1;
      if (!redirect_i && stall_i && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + 32'd1;
      if (!redirect_i && !stall_i && perf_fetch_o != '1)
        perf_fetch_o <= perf_fetch_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage against a 1-cycle synchronous imem returning addr ^ 32'hA5A5_0000.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
  } step_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] id_pc, id_pc4, id_inst;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_redirect;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  step_t plan[$];
  exp_t  sb[$];

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .id_pc_o       (id_pc),
    .id_pc4_o      (id_pc4),
    .id_inst_o     (id_inst),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_o    (perf_fetch),
    .perf_stall_o    (perf_stall),
    .perf_redirect_o (perf_redirect),
`endif
    .id_valid_o    (id_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en) imem_rdata <= imem_addr ^ SALT;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic valid, input logic [31:0] pc);
    step_t s;
    s.st = st; s.rd = rd; s.rpc = rpc; s.valid = valid; s.pc = pc;
    plan.push_back(s);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    tick(); tick();
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", imem_en); end
    n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_addr: got %h want 00003000", imem_addr); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_checks++; if (id_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", id_inst, NOP); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    rst = 1'b0;
    #1;
    n_checks++; if (imem_en !== 1'b1) begin n_fail++; $display("FAIL release_en: got %b want 1", imem_en); end
  endtask

  task automatic test_sequential();
    step_t s; exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 32'h3000 + 32'(4 * i));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      stall = s.st; redirect = s.rd; redirect_pc = s.rpc;
      sb.push_back('{s.valid, s.pc, s.valid ? (s.pc ^ SALT) : NOP});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (id_valid !== e.valid || id_inst !== e.inst ||
          (e.valid && (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4))) begin
        n_fail++;
        $display("FAIL seq: got v=%b pc=%h pc4=%h inst=%h, want v=%b pc=%h inst=%h",
                 id_valid, id_pc, id_pc4, id_inst, e.valid, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_stall();
    step_t s; exp_t e;
    do_reset();
    add(0, 0, 0, 1, 32'h3000); add(0, 0, 0, 1, 32'h3004); add(0, 0, 0, 1, 32'h3008);
    add(1, 0, 0, 1, 32'h3008); add(1, 0, 0, 1, 32'h3008); add(1, 0, 0, 1, 32'h3008);
    add(0, 0, 0, 1, 32'h300C); add(0, 0, 0, 1, 32'h3010);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      stall = s.st; redirect = s.rd; redirect_pc = s.rpc;
      sb.push_back('{s.valid, s.pc, s.valid ? (s.pc ^ SALT) : NOP});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (id_valid !== e.valid || id_inst !== e.inst ||
          (e.valid && (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4))) begin
        n_fail++;
        $display("FAIL stall: got v=%b pc=%h inst=%h, want v=%b pc=%h inst=%h",
                 id_valid, id_pc, id_inst, e.valid, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_redirect();
    step_t s; exp_t e;
    do_reset();
    add(0, 0, 0, 1, 32'h3000); add(0, 0, 0, 1, 32'h3004);
    add(0, 1, 32'h3100, 0, 0);
    add(0, 0, 0, 1, 32'h3100); add(0, 0, 0, 1, 32'h3104);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      stall = s.st; redirect = s.rd; redirect_pc = s.rpc;
      sb.push_back('{s.valid, s.pc, s.valid ? (s.pc ^ SALT) : NOP});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (id_valid !== e.valid || id_inst !== e.inst ||
          (e.valid && (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4))) begin
        n_fail++;
        $display("FAIL redirect: got v=%b pc=%h inst=%h, want v=%b pc=%h inst=%h",
                 id_valid, id_pc, id_inst, e.valid, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_stall_redirect();
    step_t s; exp_t e;
    do_reset();
    add(0, 0, 0, 1, 32'h3000); add(0, 0, 0, 1, 32'h3004);
    add(1, 0, 0, 1, 32'h3004); add(1, 0, 0, 1, 32'h3004);
    add(1, 1, 32'h3200, 0, 0);
    add(0, 0, 0, 1, 32'h3200); add(0, 0, 0, 1, 32'h3204);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      stall = s.st; redirect = s.rd; redirect_pc = s.rpc;
      sb.push_back('{s.valid, s.pc, s.valid ? (s.pc ^ SALT) : NOP});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (id_valid !== e.valid || id_inst !== e.inst ||
          (e.valid && (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4))) begin
        n_fail++;
        $display("FAIL stall_redirect: got v=%b pc=%h inst=%h, want v=%b pc=%h inst=%h",
                 id_valid, id_pc, id_inst, e.valid, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_align_wrap();
    step_t s; exp_t e;
    do_reset();
    add(0, 0, 0, 1, 32'h3000);
    add(0, 1, 32'h3103, 0, 0);
    add(0, 0, 0, 1, 32'h3100); add(0, 0, 0, 1, 32'h3104);
    add(0, 1, 32'hFFFF_FFFC, 0, 0);
    add(0, 0, 0, 1, 32'hFFFF_FFFC); add(0, 0, 0, 1, 32'h0000_0000); add(0, 0, 0, 1, 32'h0000_0004);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      stall = s.st; redirect = s.rd; redirect_pc = s.rpc;
      sb.push_back('{s.valid, s.pc, s.valid ? (s.pc ^ SALT) : NOP});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (id_valid !== e.valid || id_inst !== e.inst ||
          (e.valid && (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4))) begin
        n_fail++;
        $display("FAIL align_wrap: got v=%b pc=%h pc4=%h inst=%h, want v=%b pc=%h inst=%h",
                 id_valid, id_pc, id_pc4, id_inst, e.valid, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    step_t s; exp_t e;
    do_reset();
    add(0, 0, 0, 1, 32'h3000); add(0, 0, 0, 1, 32'h3004); add(0, 0, 0, 1, 32'h3008);
    add(1, 0, 0, 1, 32'h3008); add(1, 0, 0, 1, 32'h3008);
    add(0, 1, 32'h3300, 0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      stall = s.st; redirect = s.rd; redirect_pc = s.rpc;
      sb.push_back('{s.valid, s.pc, s.valid ? (s.pc ^ SALT) : NOP});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (id_valid !== e.valid || id_inst !== e.inst ||
          (e.valid && (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4))) begin
        n_fail++;
        $display("FAIL pre_rst: got v=%b pc=%h inst=%h, want v=%b pc=%h inst=%h",
                 id_valid, id_pc, id_inst, e.valid, e.pc, e.inst);
      end
    end
`ifdef IF_PERF_CNT_EN
    n_checks++; if (perf_fetch !== 32'd3) begin n_fail++; $display("FAIL perf_fetch: got %0d want 3", perf_fetch); end
    n_checks++; if (perf_stall !== 32'd2) begin n_fail++; $display("FAIL perf_stall: got %0d want 2", perf_stall); end
    n_checks++; if (perf_redirect !== 32'd1) begin n_fail++; $display("FAIL perf_redirect: got %0d want 1", perf_redirect); end
`endif
    // Back into HOLD, then hit reset asynchronously between edges.
    stall = 1'b0; redirect = 1'b0;
    tick(); tick();
    stall = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", id_valid); end
    n_checks++; if (id_inst !== NOP) begin n_fail++; $display("FAIL mid_rst_inst: got %h want %h", id_inst, NOP); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc: got %h want 0", id_pc); end
    n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL mid_rst_addr: got %h want 00003000", imem_addr); end
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %b want 0", imem_en); end
`ifdef IF_PERF_CNT_EN
    n_checks++;
    if (perf_fetch !== 0 || perf_stall !== 0 || perf_redirect !== 0) begin
      n_fail++;
      $display("FAIL perf_clear: got %0d/%0d/%0d want 0/0/0", perf_fetch, perf_stall, perf_redirect);
    end
`endif
    stall = 1'b0;
    tick();
    rst = 1'b0;
    add(0, 0, 0, 1, 32'h3000); add(0, 0, 0, 1, 32'h3004);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      stall = s.st; redirect = s.rd; redirect_pc = s.rpc;
      sb.push_back('{s.valid, s.pc, s.valid ? (s.pc ^ SALT) : NOP});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (id_valid !== e.valid || id_inst !== e.inst ||
          (e.valid && (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4))) begin
        n_fail++;
        $display("FAIL post_rst: got v=%b pc=%h inst=%h, want v=%b pc=%h inst=%h",
                 id_valid, id_pc, id_inst, e.valid, e.pc, e.inst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_align_wrap();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined Cpu. It feeds the decode stage.
- Holds the PC and issues addresses to a synchronous-read instruction memory with 1-cycle read latency.
- Presents the IF/ID pipeline register contents (pc, pc+4, inst, valid) to decode.
- Supports a stall from the hazard unit and a redirect from EX branch/jump resolution, with a hold buffer so no instruction is lost or duplicated while stalled.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_3000, first fetch address after reset
NOP_INST, 32'h0000_0013, instruction driven to decode when id_valid_o=0 (addi x0,x0,0)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  hazard unit: hold PC and IF/ID contents this cycle
redirect_i  in  1  EX: taken branch/jump, refetch from redirect_pc_i
redirect_pc_i  in  XLEN  redirect target
imem_en_o  out  1  imem read enable
imem_addr_o  out  XLEN  imem byte address (= pc_q)
imem_rdata_i  in  XLEN  imem data for address presented previous cycle
id_pc_o  out  XLEN  PC of instruction in IF/ID
id_pc4_o  out  XLEN  id_pc_o + 4
id_inst_o  out  XLEN  instruction in IF/ID
id_valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Registers:
  - pc_q: next fetch address.
  - req_pc_q, req_valid_q: address whose data is on imem_rdata_i, or in the hold buffer.
  - hold_inst_q.
  - state in {RUN, HOLD}.
- Reset (async, rst=1):
  - pc_q=RESET_PC, req_pc_q=0, req_valid_q=0, hold_inst_q=0, state=RUN.
  - Outputs during reset: imem_en_o=0, imem_addr_o=RESET_PC, id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0.
- Combinational outputs:
  - imem_en_o=~rst.
  - imem_addr_o=pc_q.
  - id_pc_o=req_pc_q.
  - id_pc4_o=req_pc_q+4.
  - id_valid_o=req_valid_q.
  - id_inst_o:
    - NOP_INST when !req_valid_q;
    - else hold_inst_q when state=HOLD;
    - else imem_rdata_i.
- Per rising edge, priority redirect > stall > advance:
  - Redirect:
    - pc_q<=redirect_pc_i with bits [1:0] forced to 0.
    - req_valid_q<=0 (kills in-flight fetch).
    - state<=RUN.
  - Stall (no redirect):
    - pc_q, req_pc_q, req_valid_q hold.
    - If state=RUN: hold_inst_q<=imem_rdata_i, state<=HOLD.
    - If state=HOLD: no change. Imem keeps reading pc_q; its output is ignored until release.
  - Advance:
    - req_pc_q<=pc_q, req_valid_q<=1.
    - pc_q<=pc_q+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
    - state<=RUN. The released instruction is visible on the edge of release only.
- Latency:
  - First valid instruction: id_valid_o=1 with id_pc_o=RESET_PC on the 1st rising edge after rst deasserts.
  - Redirect at edge N: bubble (valid=0) after N; target valid after edge N+1.
- Simultaneous stall_i and redirect_i: redirect wins; the stall is ignored that cycle.
- rst asserted mid-stall or mid-redirect returns everything to reset values immediately.
- No stall/redirect cycle loses or repeats an instruction.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds three 32-bit output counters, cleared by rst and saturating at 32'hFFFF_FFFF:
  - perf_fetch_o: advance edges with req_valid_q<=1;
  - perf_stall_o: edges with stall_i=1 and redirect_i=0;
  - perf_redirect_o: edges with redirect_i=1.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN;
  - RESET_PC and NOP_INST defaults;
  - the IF state enum (RUN/HOLD).
- One sub-module, if_hold_buf: hold_inst_q plus state and the id_inst_o mux. The PC logic stays in the top.

Test Plan:
- Reset release, no stall, imem returns addr^32'hA5A5_0000: edges 1..4 give id_pc_o=0x3000,0x3004,0x3008,0x300C, all valid, with matching inst.
- stall_i high 3 cycles while id_pc_o=0x3008: id_pc_o/id_inst_o stay 0x3008/its word for 3 cycles. Next edge gives 0x300C; no skip, no duplicate.
- redirect_i with target 0x3100 at edge N (id_pc_o=0x3004): after N, id_valid_o=0 and id_inst_o=0x0000_0013. After N+1, id_pc_o=0x3100, valid.
- stall_i and redirect_i (target 0x3200) asserted together while in HOLD: redirect wins, state returns to RUN, one bubble, then 0x3200.
- redirect_pc_i=0x3103: fetch from 0x3100. Redirect to 0xFFFF_FFFC: next PCs are 0xFFFF_FFFC then 0x0000_0000.
- rst pulsed mid-HOLD: outputs immediately at reset values; refetch from 0x3000. With IF_PERF_CNT_EN, counters read 0.
